busca_decodificacao: RTL and testbench

//  Fetch/decode stage directly upstream of the 5->8 bit sign extender.

---
 rtl/busca_decodificacao.sv | 88 ++++++++
 tb/tb_busca_decodificacao.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/busca_decodificacao.sv
// Fetch/decode stage: reads 8-bit words from a synchronous instruction memory and
// presents opcode/immediate/PC downstream behind a valid/ready handshake.
module busca_decodificacao #(
  parameter int                    LARGURA_PC  = 8,
  parameter logic [LARGURA_PC-1:0] PC_INICIAL  = '0,
  parameter logic [2:0]            OPCODE_HALT = 3'b111
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Habilita,
  output logic                  Mem_Le,
  output logic [LARGURA_PC-1:0] Mem_Endereco,
  input  logic [7:0]            Mem_Dado,
  input  logic                  Desvio,
  input  logic [LARGURA_PC-1:0] Desvio_Alvo,
  output logic                  Saida_Valido,
  input  logic                  Saida_Pronto,
  output logic [2:0]            Opcode,
  output logic [4:0]            Imediato,
  output logic [LARGURA_PC-1:0] PC_Instr,
  output logic                  Parado,
  output logic [2:0]            Estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BUSCA   = 3'd1,
    ESPERA  = 3'd2,
    ENTREGA = 3'd3,
    PARADO  = 3'd4
  } estado_t;

  // Handshake: an instruction is transferred on a rising edge where
  // Saida_Valido and Saida_Pronto are both high; the payload holds until then.

  estado_t               estado;
  estado_t               proximo;
  logic [LARGURA_PC-1:0] pc;
  logic [7:0]            ir;
  logic                  desvio_ativo;

  always_comb begin
    proximo      = estado;
    desvio_ativo = Desvio && (estado inside {BUSCA, ESPERA, ENTREGA});
    case (estado)
      OCIOSO:  if (Habilita) proximo = BUSCA;
      BUSCA:   proximo = ESPERA;
      ESPERA:  proximo = ENTREGA;
      ENTREGA: if (Saida_Pronto)
                 proximo = (ir[7:5] == OPCODE_HALT) ? PARADO : BUSCA;
      PARADO:  proximo = PARADO;
      default: proximo = OCIOSO;
    endcase
    // A redirect overrides every transition, including the one into PARADO.
    if (desvio_ativo) proximo = BUSCA;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      estado       <= OCIOSO;
      pc           <= PC_INICIAL;
      ir           <= 8'h00;
      PC_Instr     <= '0;
      Mem_Le       <= 1'b0;
      Saida_Valido <= 1'b0;
      Parado       <= 1'b0;
    end else begin
      estado       <= proximo;
      Mem_Le       <= (proximo == BUSCA);
      Saida_Valido <= (proximo == ENTREGA);
      Parado       <= (proximo == PARADO);
      // On redirect the word returning from memory is dropped; IR keeps the old one.
      if (desvio_ativo) begin
        pc <= Desvio_Alvo;
      end else if (estado == ESPERA) begin
        ir       <= Mem_Dado;
        PC_Instr <= pc;
        pc       <= pc + LARGURA_PC'(1);
      end
    end
  end

  assign Mem_Endereco = pc;
  assign Opcode       = ir[7:5];
  assign Imediato     = ir[4:0];
  assign Estado       = estado;

endmodule

// File: tb/tb_busca_decodificacao.sv
// Directed bench for busca_decodificacao: per-cycle vector tables plus hand-written
// stall, redirect, wrap, halt and reset sequences, with a scoreboard of accepted words.
module tb_busca_decodificacao;

  logic       Clock;
  logic       Resetn;
  logic       Habilita;
  logic       Mem_Le;
  logic [7:0] Mem_Endereco;
  logic [7:0] Mem_Dado;
  logic       Desvio;
  logic [7:0] Desvio_Alvo;
  logic       Saida_Valido;
  logic       Saida_Pronto;
  logic [2:0] Opcode;
  logic [4:0] Imediato;
  logic [7:0] PC_Instr;
  logic       Parado;
  logic [2:0] Estado;

  busca_decodificacao dut (
    .Clock(Clock), .Resetn(Resetn), .Habilita(Habilita),
    .Mem_Le(Mem_Le), .Mem_Endereco(Mem_Endereco), .Mem_Dado(Mem_Dado),
    .Desvio(Desvio), .Desvio_Alvo(Desvio_Alvo),
    .Saida_Valido(Saida_Valido), .Saida_Pronto(Saida_Pronto),
    .Opcode(Opcode), .Imediato(Imediato), .PC_Instr(PC_Instr),
    .Parado(Parado), .Estado(Estado)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous instruction memory: data one cycle after the read strobe
  logic [7:0] mem [256];
  always @(posedge Clock) if (Mem_Le) Mem_Dado <= mem[Mem_Endereco];

  int total = 0;
  int bad   = 0;

  // Scoreboard: {PC_Instr, instruction} of every accepted word, in order
  logic [15:0] exp_q[$];

  typedef struct {
    logic       hab, pr, ds;
    logic [7:0] al;
    logic       le;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] instr;
    logic [7:0] pci;
    logic       parado;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(logic hab, logic pr, logic ds, logic [7:0] al, logic le,
                              logic [7:0] addr, logic valid, logic [7:0] instr,
                              logic [7:0] pci, logic parado);
    vec_t v;
    v.hab = hab; v.pr = pr; v.ds = ds; v.al = al; v.le = le; v.addr = addr;
    v.valid = valid; v.instr = instr; v.pci = pci; v.parado = parado;
    return v;
  endfunction

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    total++;
    if (atual !== esperado) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  task automatic expect_outs(input string tag, input logic le, input logic [7:0] addr,
                             input logic valid, input logic [7:0] instr,
                             input logic [7:0] pci, input logic parado);
    check({tag, ".mem_le"}, 32'(Mem_Le), 32'(le));
    if (le) check({tag, ".addr"}, 32'(Mem_Endereco), 32'(addr));
    check({tag, ".valid"},    32'(Saida_Valido), 32'(valid));
    check({tag, ".opcode"},   32'(Opcode),       32'(instr[7:5]));
    check({tag, ".imediato"}, 32'(Imediato),     32'(instr[4:0]));
    check({tag, ".pc_instr"}, 32'(PC_Instr),     32'(pci));
    check({tag, ".parado"},   32'(Parado),       32'(parado));
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Inputs of entry k act during the state observed after entry k-1
  task automatic run_tab(input string nome);
    for (int i = 0; i < tab.size(); i++) begin
      Habilita     = tab[i].hab;
      Saida_Pronto = tab[i].pr;
      Desvio       = tab[i].ds;
      Desvio_Alvo  = tab[i].al;
      tick();
      expect_outs($sformatf("%s[%0d]", nome, i), tab[i].le, tab[i].addr, tab[i].valid,
                  tab[i].instr, tab[i].pci, tab[i].parado);
    end
    tab.delete();
  endtask

  // Scoreboard monitor, sampled mid-cycle before the accepting edge
  always @(negedge Clock) begin
    if (Resetn && Saida_Valido && Saida_Pronto) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got=%0h expected=none", {PC_Instr, Opcode, Imediato});
      end else begin
        check("sb_accept", 32'({PC_Instr, Opcode, Imediato}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    Resetn = 1'b0; Habilita = 1'b0; Desvio = 1'b0; Desvio_Alvo = 8'h00; Saida_Pronto = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h56; mem[1] = 8'h3A; mem[2] = 8'h9F; mem[3] = 8'h41;
    mem[4] = 8'h7B; mem[8'h40] = 8'hE5; mem[8'hFF] = 8'hA3; mem[8'h10] = 8'h2C;
    exp_q = '{16'h0056, 16'h013A, 16'h029F, 16'h0341, 16'h40E5, 16'hFFA3,
              16'h0011, 16'h0122, 16'h02E0};

    repeat (2) @(posedge Clock);
    #1;
    expect_outs("reset", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    check("reset.addr", 32'(Mem_Endereco), 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    tick();

    // First fetch and back-to-back stream with Pronto held high
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h56, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h56, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h56, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h3A, 8'h01, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 1, 8'h02, 0, 8'h3A, 8'h01, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h3A, 8'h01, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h9F, 8'h02, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 1, 8'h03, 0, 8'h9F, 8'h02, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h9F, 8'h02, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h41, 8'h03, 0));
    run_tab("stream");

    // Downstream stall: payload frozen, no fetch
    Saida_Pronto = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_outs($sformatf("stall[%0d]", i), 1'b0, 8'h00, 1'b1, 8'h41, 8'h03, 1'b0);
    end
    Saida_Pronto = 1'b1;
    tick();
    expect_outs("stall_release", 1'b1, 8'h04, 1'b0, 8'h41, 8'h03, 1'b0);
    Saida_Pronto = 1'b0;

    // Redirect during ESPERA drops the word read from address 4
    tick();
    Desvio = 1'b1; Desvio_Alvo = 8'h40;
    tick();
    expect_outs("desvio_espera", 1'b1, 8'h40, 1'b0, 8'h41, 8'h03, 1'b0);
    Desvio = 1'b0;
    tick();
    tick();
    expect_outs("desvio_entrega", 1'b0, 8'h00, 1'b1, 8'hE5, 8'h40, 1'b0);

    // HALT accepted together with a redirect: redirect wins
    Saida_Pronto = 1'b1; Desvio = 1'b1; Desvio_Alvo = 8'hFF;
    tick();
    expect_outs("halt_vs_desvio", 1'b1, 8'hFF, 1'b0, 8'hE5, 8'h40, 1'b0);
    Saida_Pronto = 1'b0; Desvio = 1'b0;
    tick();
    tick();
    expect_outs("fetch_ff", 1'b0, 8'h00, 1'b1, 8'hA3, 8'hFF, 1'b0);
    Saida_Pronto = 1'b1;
    tick();
    expect_outs("wrap", 1'b1, 8'h00, 1'b0, 8'hA3, 8'hFF, 1'b0);
    Saida_Pronto = 1'b0;

    // Redirect in BUSCA restarts the fetch at the target
    Desvio = 1'b1; Desvio_Alvo = 8'h10;
    tick();
    expect_outs("desvio_busca", 1'b1, 8'h10, 1'b0, 8'hA3, 8'hFF, 1'b0);
    Desvio = 1'b0;
    tick();
    tick();
    expect_outs("fetch_10", 1'b0, 8'h00, 1'b1, 8'h2C, 8'h10, 1'b0);

    // Asynchronous reset mid-ENTREGA clears everything before any edge
    #1 Resetn = 1'b0;
    #1;
    expect_outs("reset_async", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    check("reset_async.addr", 32'(Mem_Endereco), 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hE0; mem[3] = 8'h33;
    tick();

    // HALT at address 2, then Habilita/Desvio must have no effect
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h11, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h11, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h11, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h22, 8'h01, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 1, 8'h02, 0, 8'h22, 8'h01, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h22, 8'h01, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 8'hE0, 8'h02, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'hE0, 8'h02, 1));
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(1, 1, 1, 8'h30, 0, 8'h00, 0, 8'hE0, 8'h02, 1));
    run_tab("halt");
    Habilita = 1'b0; Desvio = 1'b0; Saida_Pronto = 1'b0;
    tick();

    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
